// File: rtl/he_pkg.sv
`default_nettype none
// ============================================================================
// Module   : he_pkg
// Brief    : Shared types and constants for the histogram-equalisation engine.
// Revision : 1.0 - initial release
// ============================================================================
package he_pkg;

  localparam int NUM_BINS         = 256;
  localparam int CNT_W            = 32;
  localparam int DEF_IMAGE_WIDTH  = 660;
  localparam int DEF_IMAGE_HEIGHT = 440;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    HIST  = 3'd2,
    CDF   = 3'd3,
    DONE  = 3'd4
  } he_state_t;

endpackage : he_pkg
`default_nettype wire

// File: rtl/he_lut_scale.sv
`default_nettype none
// ============================================================================
// Module   : he_lut_scale
// Brief    : Maps a CDF value to a LUT entry, min(255, s*255/NUM_PIXELS).
// Revision : 1.0 - initial release
// ============================================================================
module he_lut_scale #(
  parameter int CNT_W      = 32,
  parameter int NUM_PIXELS = 290400
) (
  input  logic [CNT_W-1:0] s,
  output logic [7:0]       lut_val
);

  localparam logic [CNT_W-1:0] C_SCALE = CNT_W'(255);
  localparam logic [CNT_W-1:0] C_DIV   = CNT_W'(NUM_PIXELS);

  logic [CNT_W-1:0] w_prod;
  logic [CNT_W-1:0] w_quot;

  // Constant divisor; kept in its own block so a reciprocal multiply can drop in.
  always_comb begin
    w_prod  = s * C_SCALE;
    w_quot  = w_prod / C_DIV;
    lut_val = (w_quot > C_SCALE) ? 8'hFF : w_quot[7:0];
  end

endmodule : he_lut_scale
`default_nettype wire

// File: rtl/he_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : he_frame_ctrl
// Brief    : Per-frame sequencer: clear bins, histogram, CDF scan, LUT emit.
// Revision : 1.0 - initial release
// ============================================================================
module he_frame_ctrl
  import he_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int NUM_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [7:0]       pixel_value,
  output logic             pix_ready,
  output logic [7:0]       mem_addr,
  output logic             mem_we,
  output logic [CNT_W-1:0] mem_wdata,
  input  logic [CNT_W-1:0] mem_rdata,
  output logic             lut_we,
  output logic [7:0]       lut_addr,
  output logic [7:0]       lut_wdata,
  output logic             busy,
  output logic [2:0]       phase,
  output logic             done,
  output logic             err_count
);

  localparam int PIX_CNT_W = $clog2(NUM_PIXELS + 1);
  localparam logic [PIX_CNT_W-1:0] C_PIX_LAST = PIX_CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0]     C_PIX_TOT  = CNT_W'(NUM_PIXELS);
  localparam logic [7:0]           C_BIN_LAST = 8'(NUM_BINS - 1);

  he_state_t             r_state,   w_state_nxt;
  logic [7:0]            r_bin,     w_bin_nxt;
  logic                  r_sub,     w_sub_nxt;
  logic [7:0]            r_pix_addr, w_pix_addr_nxt;
  logic [PIX_CNT_W-1:0]  r_pix_cnt, w_pix_cnt_nxt;
  logic [CNT_W-1:0]      r_acc,     w_acc_nxt;
  logic                  r_err,     w_err_nxt;

  logic [CNT_W-1:0]      w_sum;
  logic [7:0]            w_lut_val;

  assign w_sum = r_acc + mem_rdata;

  he_lut_scale #(
    .CNT_W      (CNT_W),
    .NUM_PIXELS (NUM_PIXELS)
  ) u_lut_scale (
    .s       (w_sum),
    .lut_val (w_lut_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bin      <= 8'd0;
      r_sub      <= 1'b0;
      r_pix_addr <= 8'd0;
      r_pix_cnt  <= '0;
      r_acc      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bin      <= w_bin_nxt;
      r_sub      <= w_sub_nxt;
      r_pix_addr <= w_pix_addr_nxt;
      r_pix_cnt  <= w_pix_cnt_nxt;
      r_acc      <= w_acc_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // r_sub selects the first (read) or second (write) cycle of each two-cycle access.
  always_comb begin
    w_state_nxt    = r_state;
    w_bin_nxt      = r_bin;
    w_sub_nxt      = r_sub;
    w_pix_addr_nxt = r_pix_addr;
    w_pix_cnt_nxt  = r_pix_cnt;
    w_acc_nxt      = r_acc;
    w_err_nxt      = r_err;
    pix_ready      = 1'b0;
    mem_addr       = 8'd0;
    mem_we         = 1'b0;
    mem_wdata      = '0;
    lut_we         = 1'b0;
    lut_addr       = 8'd0;
    lut_wdata      = 8'd0;
    done           = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CLEAR;
          w_bin_nxt   = 8'd0;
          w_err_nxt   = 1'b0;
        end
      end

      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_bin;
        if (r_bin == C_BIN_LAST) begin
          w_state_nxt   = HIST;
          w_sub_nxt     = 1'b0;
          w_pix_cnt_nxt = '0;
        end else begin
          w_bin_nxt = r_bin + 8'd1;
        end
      end

      HIST: begin
        if (!r_sub) begin
          pix_ready = 1'b1;
          if (pix_valid) begin
            mem_addr       = pixel_value;
            w_pix_addr_nxt = pixel_value;
            w_pix_cnt_nxt  = r_pix_cnt + PIX_CNT_W'(1);
            w_sub_nxt      = 1'b1;
          end
        end else begin
          mem_we    = 1'b1;
          mem_addr  = r_pix_addr;
          mem_wdata = mem_rdata + CNT_W'(1);
          w_sub_nxt = 1'b0;
          if (r_pix_cnt == C_PIX_LAST) begin
            w_state_nxt = CDF;
            w_bin_nxt   = 8'd0;
            w_acc_nxt   = '0;
          end
        end
      end

      CDF: begin
        mem_addr = r_bin;
        if (!r_sub) begin
          w_sub_nxt = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = w_sum;
          lut_we    = 1'b1;
          lut_addr  = r_bin;
          lut_wdata = w_lut_val;
          w_acc_nxt = w_sum;
          w_sub_nxt = 1'b0;
          if (r_bin == C_BIN_LAST) begin
            w_err_nxt   = (w_sum != C_PIX_TOT);
            w_state_nxt = DONE;
          end else begin
            w_bin_nxt = r_bin + 8'd1;
          end
        end
      end

      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign phase     = r_state;
  assign err_count = r_err;

endmodule : he_frame_ctrl
`default_nettype wire

// File: tb/tb_he_frame_ctrl.sv
`default_nettype none
// Randomised frame bench with a reference histogram/CDF model and a LUT scoreboard.
module tb_he_frame_ctrl;
  import he_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             pix_valid;
  logic [7:0]       pixel_value;
  logic             pix_ready;
  logic [7:0]       mem_addr;
  logic             mem_we;
  logic [CNT_W-1:0] mem_wdata;
  logic [CNT_W-1:0] mem_rdata;
  logic             lut_we;
  logic [7:0]       lut_addr;
  logic [7:0]       lut_wdata;
  logic             busy;
  logic [2:0]       phase;
  logic             done;
  logic             err_count;

  always #5 clk = ~clk;

  he_frame_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pix_valid   (pix_valid),
    .pixel_value (pixel_value),
    .pix_ready   (pix_ready),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .lut_we      (lut_we),
    .lut_addr    (lut_addr),
    .lut_wdata   (lut_wdata),
    .busy        (busy),
    .phase       (phase),
    .done        (done),
    .err_count   (err_count)
  );

  // Bin RAM model: synchronous read, one-cycle latency, optional fault on first HIST write.
  logic [CNT_W-1:0] ram [256];
  int               edges = 0;
  int               hw = 0;
  bit               fault_req = 1'b0;

  always @(posedge clk) begin
    edges <= edges + 1;
    if (edges == 0) begin
      for (int i = 0; i < 256; i++) ram[i] <= $urandom;
    end else if (mem_we) begin
      if (phase == 3'd2 && fault_req && hw == 0) ram[mem_addr] <= mem_wdata + 3;
      else                                        ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
    if (phase == 3'd1)                hw <= 0;
    else if (mem_we && phase == 3'd2) hw <= hw + 1;
  end

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [2:0] prev_phase = 3'd0;

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops expected LUT entries whenever the DUT strobes lut_we.
  always @(negedge clk) begin
    if (lut_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("lut_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("lut_addr", lut_addr, e.addr);
        chk("lut_data", lut_wdata, e.data);
      end
    end
    if (pix_ready === 1'b1 && phase != 3'd2) chk("ready_phase", phase, 2);
    if (phase == 3'd2 && prev_phase == 3'd1) begin
      int nz;
      nz = 0;
      for (int i = 0; i < 256; i++) if (ram[i] != 0) nz++;
      chk("clear_zero", nz, 0);
    end
    prev_phase = phase;
  end

  // pmode: 0 all 100, 1 ramp 0..7, 2 all 255, 3 random
  // smode: 0 none, 1 three stall cycles per pixel, 2 random 0..3
  task automatic run_frame(input int pmode, input int smode, input bit fault,
                           input bit pulse_start, input int abort_bin);
    logic [7:0] px[N];
    int         stalls[N];
    int         hist[256];
    int         tot_stall, acc, v, idx, st, extra, t0, cyc;
    bit         pulsed, seen_done, exp_err;

    tot_stall = 0;
    for (int i = 0; i < N; i++) begin
      case (pmode)
        0:       px[i] = 8'd100;
        1:       px[i] = 8'(i);
        2:       px[i] = 8'd255;
        default: px[i] = 8'($urandom_range(0, 255));
      endcase
      case (smode)
        0:       stalls[i] = 0;
        1:       stalls[i] = 3;
        default: stalls[i] = $urandom_range(0, 3);
      endcase
      tot_stall += stalls[i];
    end

    for (int k = 0; k < 256; k++) hist[k] = 0;
    for (int i = 0; i < N; i++) hist[px[i]]++;
    if (fault) hist[px[0]] += 3;
    acc = 0;
    for (int k = 0; k < 256; k++) begin
      acc += hist[k];
      v = (acc * 255) / N;
      if (v > 255) v = 255;
      exp_q.push_back('{addr: k, data: v});
    end
    exp_err   = (acc != N);
    fault_req = fault;

    @(negedge clk);
    start       = 1'b1;
    pix_valid   = 1'b1;
    pixel_value = 8'($urandom);
    t0          = edges;
    idx = 0; st = stalls[0]; extra = 0; pulsed = 0; seen_done = 0;

    for (int c = 0; c < 3000 && !seen_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      cyc   = edges - t0;
      if (cyc == 1) begin
        chk("err_cleared_on_start", err_count, 0);
        chk("phase_clear", phase, 1);
      end
      if (pulse_start && !pulsed && phase == 3'd2) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (pix_ready) begin
        if (idx < N && st > 0) begin
          pix_valid = 1'b0;
          st--;
        end else if (idx < N) begin
          pix_valid   = 1'b1;
          pixel_value = px[idx];
          idx++;
          st = (idx < N) ? stalls[idx] : 0;
        end else begin
          pix_valid   = 1'b1;
          pixel_value = 8'($urandom);
          extra++;
        end
      end else begin
        pix_valid   = 1'($urandom);
        pixel_value = 8'($urandom);
      end

      if (abort_bin >= 0 && lut_we && int'(lut_addr) == abort_bin) begin
        reset     = 1'b1;
        pix_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_phase", phase, 0);
        chk("abort_lut_we", lut_we, 0);
        chk("abort_mem_we", mem_we, 0);
        reset = 1'b0;
        exp_q.delete();
        fault_req = 1'b0;
        return;
      end

      if (done) begin
        seen_done = 1'b1;
        chk("done_cycle", cyc, 769 + 2 * N + tot_stall);
        chk("err_count", err_count, exp_err);
        chk("lut_left", exp_q.size(), 0);
        chk("extra_pixels", extra, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
      end
    end
    if (!seen_done) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
    pix_valid = 1'b0;
    fault_req = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    pix_valid   = 1'b0;
    pixel_value = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_phase", phase, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_lut_we", lut_we, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 0, 1'b0, 1'b0, -1);
    chk("bin100_ram", ram[100], 8);
    run_frame(1, 0, 1'b0, 1'b0, -1);
    run_frame(1, 1, 1'b0, 1'b0, -1);
    run_frame(2, 0, 1'b0, 1'b1, -1);
    run_frame(3, 2, 1'b0, 1'b0, -1);
    run_frame(3, 2, 1'b0, 1'b0, 40);
    run_frame(3, 2, 1'b0, 1'b0, -1);
    run_frame(3, 0, 1'b1, 1'b0, -1);
    repeat (10) @(negedge clk);
    chk("err_sticky", err_count, 1);
    for (int f = 0; f < 3; f++) run_frame(3, 2, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_he_frame_ctrl
`default_nettype wire

// File: doc/he_frame_ctrl.md
Name: he_frame_ctrl

Overview:
- Sequencing controller for the histogram-equalisation engine. For each frame it owns a single-port 256-entry bin RAM and runs four phases in order: clear bins, accumulate histogram from the pixel stream, scan the CDF, emit the 256-entry transformation LUT.
- Sits between the pixel source and the LUT-apply stage. It replaces the ad-hoc all-in-one-cycle loops with a bounded one-memory-access-per-cycle schedule.

Parameters:
- IMAGE_WIDTH, 660, pixels per line
- IMAGE_HEIGHT, 440, lines per frame
- NUM_PIXELS, IMAGE_WIDTH*IMAGE_HEIGHT, pixels per frame
- NUM_BINS, 256, histogram bins (fixed at 256; 8-bit pixels)
- CNT_W, 32, bin/CDF word width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- pix_valid  in  1  pixel_value valid
- pixel_value  in  8  input pixel
- pix_ready  out  1  controller accepts pixel this cycle
- mem_addr  out  8  bin RAM address
- mem_we  out  1  bin RAM write enable
- mem_wdata  out  CNT_W  bin RAM write data
- mem_rdata  in  CNT_W  bin RAM read data; valid one cycle after address with mem_we=0
- lut_we  out  1  LUT entry write strobe
- lut_addr  out  8  LUT index
- lut_wdata  out  8  LUT value
- busy  out  1  high outside IDLE
- phase  out  3  current state encoding
- done  out  1  one-cycle pulse at frame end
- err_count  out  1  sticky: final CDF is not equal to NUM_PIXELS

Behaviour:
- One clock. Reset is synchronous and active-high, on clk/reset.
- Reset values: state IDLE; all outputs 0 except err_count, which is also 0. Reset mid-frame aborts at once with no further mem/lut writes. RAM contents are undefined until the next CLEAR.
- States:
  - IDLE(0): start=1 -> CLEAR; err_count cleared on that transition. start while busy is ignored.
  - CLEAR(1): 256 cycles, bin k = 0..255. mem_we=1, mem_addr=k, mem_wdata=0. After k=255 -> HIST.
  - HIST(2): two-cycle read-modify-write per pixel.
    - Cycle A: pix_ready=1. On pix_valid, latch the pixel, mem_addr=pixel, mem_we=0.
    - Cycle B: pix_ready=0. mem_we=1, mem_wdata=mem_rdata+1, same address.
    - No pix_valid in A: stay in A with no access.
    - pixel counter (19+ bits) increments on accept. After the B of pixel NUM_PIXELS -> CDF.
    - pix_ready is 0 in every other state, so surplus pixels are never accepted.
  - CDF(3): two cycles per bin, k = 0..255. acc starts at 0.
    - Cycle A: read bin k.
    - Cycle B: s = acc + mem_rdata. Write bin k = s (mem_we=1). lut_we=1, lut_addr=k, lut_wdata=(s*255)/NUM_PIXELS, truncated. acc <= s.
    - After bin 255, err_count <= (s != NUM_PIXELS) -> DONE.
  - DONE(4): done=1 for exactly one cycle -> IDLE.
- Arithmetic: s*255 is computed at CNT_W bits with no overflow for the defaults (max 74,052,000 < 2^27). Division is by a constant, integer, floor. A result >255 cannot occur when s <= NUM_PIXELS; saturate to 255 regardless.
- Latency: start sampled at cycle 0 with continuous pix_valid.
  - CLEAR occupies cycles 1..256.
  - HIST occupies 257..256+2N.
  - CDF occupies 257+2N..768+2N.
  - done is high in cycle 769+2N.
- Stalls on pix_valid extend HIST only.
- Pixel value 255 and bin wrap: the CDF address counter stops at 255 and does not wrap. The pixel counter does not wrap either.

Decomposition:
- Package he_pkg: state enum (IDLE, CLEAR, HIST, CDF, DONE), NUM_BINS, default image dimensions, CNT_W.
- One sub-module he_lut_scale, combinational: s -> min(255, s*255/NUM_PIXELS). Isolated so it can later be replaced by a reciprocal multiply.

Test Plan:
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2, all pixels =100, continuous valid -> LUT[0..99]=0, LUT[100..255]=255; done in cycle 785; err_count=0; bin 100 RAM =8.
- Same dimensions, pixels 0..7 -> cdf[k]=k+1 for k<8, cdf[k]=8 for k>=8; LUT[0]=31, LUT[3]=127, LUT[6]=223, LUT[7..255]=255.
- Pixels 0..7 with pix_valid low for 3 cycles before each pixel -> same LUT; done delayed by 24 cycles (cycle 809); pix_ready never high outside HIST cycle A.
- start pulsed during HIST, then pixel 255 ×8 -> start ignored; LUT[0..254]=0, LUT[255]=255; second start after done -> CLEAR restarts and the RAM is zeroed again.
- reset asserted mid-CDF (bin 40) -> next cycle busy=0, phase=0, no lut_we or mem_we; a new start then yields a correct frame.
- Force mem_rdata+1 corruption on one HIST write (bench RAM model fault) -> final s != 8, err_count=1 after CDF, held until the next start.
